// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, ALU op codes and the control bundle carried across the ID/EX boundary
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_J = 6'h02;
  localparam logic [1:0] ALU_OP_ADD = 2'b00;
  localparam logic [1:0] ALU_OP_SUB = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
  typedef struct packed {
    logic reg_dst;
    logic alu_src;
    logic mem_to_reg;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
    logic [1:0] alu_op;
  } ctrl_t;
  function automatic ctrl_t decode_ctrl(input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin c.reg_dst = 1'b1; c.reg_write = 1'b1; c.alu_op = ALU_OP_RTYPE; end
      OP_LW: begin c.alu_src = 1'b1; c.mem_to_reg = 1'b1; c.reg_write = 1'b1; c.mem_read = 1'b1; end
      OP_SW: begin c.alu_src = 1'b1; c.mem_write = 1'b1; end
      OP_BEQ: begin c.branch = 1'b1; c.alu_op = ALU_OP_SUB; end
      OP_ADDI: begin c.alu_src = 1'b1; c.reg_write = 1'b1; c.alu_op = ALU_OP_ADD; end
      OP_J: c.jump = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction
  function automatic logic is_legal(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
  endfunction
endpackage

// File: rtl/instruction_decode_register_file.sv
// register_file: 2-read/1-write register file, register 0 hardwired to zero
// ports: clk, reset (async, active-high), rd_addr_1/2 -> rd_data_1/2 (combinational),
//        wr_en/wr_addr/wr_data (posedge write).
// macro WB_BYPASS_EN: a same-cycle write to a read index is forwarded to that read.
module register_file #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W = 32,
  parameter int AW = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AW-1:0]     rd_addr_1,
  input  logic [AW-1:0]     rd_addr_2,
  output logic [DATA_W-1:0] rd_data_1,
  output logic [DATA_W-1:0] rd_data_2,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data
);
`ifdef WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  logic [DATA_W-1:0] mem [NUM_REGS];
  logic wr_ok;
  assign wr_ok = wr_en && wr_addr != '0;
  assign rd_data_1 = rd_addr_1 == '0 ? '0 : (BYPASS && wr_ok && wr_addr == rd_addr_1) ? wr_data : mem[rd_addr_1];
  assign rd_data_2 = rd_addr_2 == '0 ? '0 : (BYPASS && wr_ok && wr_addr == rd_addr_2) ? wr_data : mem[rd_addr_2];
  always_ff @(posedge clk or posedge reset)
    if (reset)
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    else if (wr_ok)
      mem[wr_addr] <= wr_data;
endmodule

// File: rtl/instruction_decode.sv
// instruction_decode: MIPS decode stage with register file, control decode, load-use stall and ID/EX register
// ports: clk, reset (async, active-high); instruction/pc_plus4 from fetch; flush (wrong-path kill);
//        wb_reg_write/wb_write_reg/wb_write_data writeback; stall (combinational, to fetch);
//        ex_* registered ID/EX outputs.
// macro WB_BYPASS_EN: enables write-before-read forwarding inside the register file.
module instruction_decode
  import mips_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instruction,
  input  logic [31:0]       pc_plus4,
  input  logic              flush,
  input  logic              wb_reg_write,
  input  logic [4:0]        wb_write_reg,
  input  logic [DATA_W-1:0] wb_write_data,
  output logic              stall,
  output logic [DATA_W-1:0] ex_read_data_1,
  output logic [DATA_W-1:0] ex_read_data_2,
  output logic [31:0]       ex_sign_ext_imm,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [4:0]        ex_shamt,
  output logic [5:0]        ex_funct,
  output logic [31:0]       ex_pc_plus4,
  output logic [31:0]       ex_branch_address,
  output logic [31:0]       ex_jump_address,
  output ctrl_t             ex_ctrl,
  output logic              ex_illegal
);
  logic [5:0] opcode;
  logic [4:0] rs, rt;
  logic [DATA_W-1:0] rd1, rd2;
  logic [31:0] imm;
  logic uses_rt, hazard, bubble;
  assign opcode = instruction[31:26];
  assign rs = instruction[25:21];
  assign rt = instruction[20:16];
  assign imm = {{16{instruction[15]}}, instruction[15:0]};
  register_file #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W)) u_rf (
    .clk(clk), .reset(reset),
    .rd_addr_1(rs), .rd_addr_2(rt), .rd_data_1(rd1), .rd_data_2(rd2),
    .wr_en(wb_reg_write), .wr_addr(wb_write_reg), .wr_data(wb_write_data)
  );
  // rt is only a source operand for R-type, sw and beq; for lw/addi it is a destination
  assign uses_rt = opcode inside {OP_RTYPE, OP_SW, OP_BEQ};
  assign hazard = ex_ctrl.mem_read && ex_rt != '0 && (ex_rt == rs || (ex_rt == rt && uses_rt));
  assign stall = hazard && !flush && !reset;
  assign bubble = hazard || flush;
  always_ff @(posedge clk or posedge reset)
    if (reset || bubble) begin
      ex_read_data_1 <= '0;
      ex_read_data_2 <= '0;
      ex_sign_ext_imm <= '0;
      ex_rs <= '0;
      ex_rt <= '0;
      ex_rd <= '0;
      ex_shamt <= '0;
      ex_funct <= '0;
      ex_pc_plus4 <= '0;
      ex_branch_address <= '0;
      ex_jump_address <= '0;
      ex_ctrl <= '0;
      ex_illegal <= 1'b0;
    end else begin
      ex_read_data_1 <= rd1;
      ex_read_data_2 <= rd2;
      ex_sign_ext_imm <= imm;
      ex_rs <= rs;
      ex_rt <= rt;
      ex_rd <= instruction[15:11];
      ex_shamt <= instruction[10:6];
      ex_funct <= instruction[5:0];
      ex_pc_plus4 <= pc_plus4;
      ex_branch_address <= pc_plus4 + {imm[29:0], 2'b00};
      ex_jump_address <= {pc_plus4[31:28], instruction[25:0], 2'b00};
      ex_ctrl <= decode_ctrl(opcode);
      ex_illegal <= !is_legal(opcode);
    end
endmodule

// File: tb/tb_instruction_decode.sv
// tb_instruction_decode: directed and random checks of instruction_decode against a behavioural model
module tb_instruction_decode;
  import mips_pkg::*;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, flush = 1'b0, wb_reg_write = 1'b0, stall, ex_illegal;
  logic [31:0] instruction = '0, pc_plus4 = '0, wb_write_data = '0;
  logic [4:0] wb_write_reg = '0, ex_rs, ex_rt, ex_rd, ex_shamt;
  logic [5:0] ex_funct;
  logic [31:0] ex_read_data_1, ex_read_data_2, ex_sign_ext_imm, ex_pc_plus4, ex_branch_address, ex_jump_address;
  ctrl_t ex_ctrl;
  int errors = 0, checks = 0;
  logic last_stall;
  logic [31:0] m_regs [32];
  logic [31:0] e_rd1, e_rd2, e_imm, e_pc, e_br, e_jmp;
  logic [4:0] e_rs, e_rt, e_rd, e_shamt;
  logic [5:0] e_funct;
  logic [9:0] e_ctrl;
  logic e_ill, e_mr;
  instruction_decode dut (
    .clk(clk), .reset(reset), .instruction(instruction), .pc_plus4(pc_plus4), .flush(flush),
    .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
    .stall(stall), .ex_read_data_1(ex_read_data_1), .ex_read_data_2(ex_read_data_2),
    .ex_sign_ext_imm(ex_sign_ext_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_shamt(ex_shamt), .ex_funct(ex_funct), .ex_pc_plus4(ex_pc_plus4),
    .ex_branch_address(ex_branch_address), .ex_jump_address(ex_jump_address),
    .ex_ctrl(ex_ctrl), .ex_illegal(ex_illegal)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // {illegal, reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, jump, alu_op}
  function automatic logic [10:0] ref_ctrl(input logic [5:0] op);
    case (op)
      6'h00: return 11'b0_1001000010;
      6'h23: return 11'b0_0111100000;
      6'h2B: return 11'b0_0100010000;
      6'h04: return 11'b0_0000001001;
      6'h08: return 11'b0_0101000000;
      6'h02: return 11'b0_0000000100;
      default: return 11'b1_0000000000;
    endcase
  endfunction
  function automatic logic [31:0] ref_read(input logic [4:0] i, input logic we, input logic [4:0] wa, input logic [31:0] wd);
    if (i == 0) return 32'h0;
    if (BYP && we && wa == i) return wd;
    return m_regs[i];
  endfunction
  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    {e_rd1, e_rd2, e_imm, e_pc, e_br, e_jmp} = '0;
    {e_rs, e_rt, e_rd, e_shamt, e_funct, e_ctrl, e_ill, e_mr} = '0;
  endtask
  task automatic check_ex();
    check("rd1", ex_read_data_1, e_rd1);
    check("rd2", ex_read_data_2, e_rd2);
    check("imm", ex_sign_ext_imm, e_imm);
    check("rs", 32'(ex_rs), 32'(e_rs));
    check("rt", 32'(ex_rt), 32'(e_rt));
    check("rd", 32'(ex_rd), 32'(e_rd));
    check("shamt", 32'(ex_shamt), 32'(e_shamt));
    check("funct", 32'(ex_funct), 32'(e_funct));
    check("pc4", ex_pc_plus4, e_pc);
    check("br", ex_branch_address, e_br);
    check("jmp", ex_jump_address, e_jmp);
    check("ctrl", 32'(ex_ctrl), 32'(e_ctrl));
    check("ill", 32'(ex_illegal), 32'(e_ill));
  endtask
  task automatic step(input logic [31:0] ins, input logic [31:0] pc, input logic fl, input logic we, input logic [4:0] wa, input logic [31:0] wd);
    logic [5:0] op;
    logic [4:0] rs, rt;
    logic src_rt, hz;
    @(negedge clk);
    instruction = ins; pc_plus4 = pc; flush = fl;
    wb_reg_write = we; wb_write_reg = wa; wb_write_data = wd;
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16];
    src_rt = op == 6'h00 || op == 6'h2B || op == 6'h04;
    hz = e_mr && e_rt != 0 && (e_rt == rs || (e_rt == rt && src_rt));
    #1;
    last_stall = stall;
    check("stall", 32'(stall), 32'(hz && !fl));
    @(posedge clk);
    if (hz || fl) model_clear_ex();
    else begin
      e_rd1 = ref_read(rs, we, wa, wd);
      e_rd2 = ref_read(rt, we, wa, wd);
      e_imm = 32'(signed'(ins[15:0]));
      e_rs = rs; e_rt = rt; e_rd = ins[15:11]; e_shamt = ins[10:6]; e_funct = ins[5:0];
      e_pc = pc;
      e_br = pc + e_imm * 4;
      e_jmp = {pc[31:28], ins[25:0], 2'b00};
      {e_ill, e_ctrl} = ref_ctrl(op);
      e_mr = op == 6'h23;
    end
    if (we && wa != 0) m_regs[wa] = wd;
    #1;
    check_ex();
  endtask
  task automatic model_clear_ex();
    {e_rd1, e_rd2, e_imm, e_pc, e_br, e_jmp} = '0;
    {e_rs, e_rt, e_rd, e_shamt, e_funct, e_ctrl, e_ill, e_mr} = '0;
  endtask
  initial begin
    logic [5:0] ops [7];
    logic [5:0] op;
    logic [31:0] ins;
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02, 6'h3F};
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", 32'(stall), 32'h0);
    check_ex();
    @(negedge clk);
    reset = 1'b0;
    step(32'h0, 32'h4, 1'b0, 1'b1, 5'd1, 32'd5);
    step(32'h0, 32'h8, 1'b0, 1'b1, 5'd2, 32'd7);
    step(32'h00221820, 32'hC, 1'b0, 1'b0, 5'd0, 32'd0);
    check("add_rd1", ex_read_data_1, 32'd5);
    check("add_rd2", ex_read_data_2, 32'd7);
    check("add_rd", 32'(ex_rd), 32'd3);
    check("add_regdst", 32'(ex_ctrl.reg_dst), 32'd1);
    check("add_aluop", 32'(ex_ctrl.alu_op), 32'd2);
    step(32'h8C240000, 32'h10, 1'b0, 1'b0, 5'd0, 32'd0);
    step(32'h00842820, 32'h14, 1'b0, 1'b0, 5'd0, 32'd0);
    check("lu_stall", 32'(last_stall), 32'd1);
    check("lu_bubble", 32'(ex_ctrl), 32'd0);
    step(32'h00842820, 32'h14, 1'b0, 1'b0, 5'd0, 32'd0);
    check("lu_issue_stall", 32'(last_stall), 32'd0);
    check("lu_issue_rd", 32'(ex_rd), 32'd5);
    step(32'h1000FFFF, 32'h100, 1'b0, 1'b0, 5'd0, 32'd0);
    check("beq_addr", ex_branch_address, 32'hFC);
    check("beq_imm", ex_sign_ext_imm, 32'hFFFFFFFF);
    check("beq_branch", 32'(ex_ctrl.branch), 32'd1);
    step(32'h8C240000, 32'h20, 1'b0, 1'b0, 5'd0, 32'd0);
    step(32'h00842820, 32'h24, 1'b1, 1'b0, 5'd0, 32'd0);
    check("fl_stall", 32'(last_stall), 32'd0);
    check("fl_bubble", 32'(ex_ctrl), 32'd0);
    step(32'h0, 32'h28, 1'b0, 1'b1, 5'd6, 32'h11);
    step(32'h00C03820, 32'h2C, 1'b0, 1'b1, 5'd6, 32'hAB);
    check("wb_same", ex_read_data_1, BYP ? 32'hAB : 32'h11);
    step(32'h00003820, 32'h30, 1'b0, 1'b1, 5'd0, 32'hFF);
    step(32'h00003820, 32'h34, 1'b0, 1'b0, 5'd0, 32'h0);
    check("r0_read", ex_read_data_1, 32'h0);
    for (int n = 0; n < 400; n++) begin
      op = ops[$urandom_range(0, 6)];
      ins = $urandom;
      ins[31:26] = op;
      ins[25:21] = 5'($urandom_range(0, 7));
      ins[20:16] = 5'($urandom_range(0, 7));
      step(ins, $urandom, $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
    end
    step(32'h8C240000, 32'h40, 1'b0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    instruction = 32'h00842820; flush = 1'b0; wb_reg_write = 1'b0;
    #1;
    check("pre_rst_stall", 32'(stall), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_stall", 32'(stall), 32'd0);
    check("mid_rst_ctrl", 32'(ex_ctrl), 32'd0);
    check("mid_rst_rt", 32'(ex_rt), 32'd0);
    check("mid_rst_pc4", ex_pc_plus4, 32'd0);
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    step(32'h00221820, 32'h44, 1'b0, 1'b0, 5'd0, 32'd0);
    check("post_rst_rd1", ex_read_data_1, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
